// File: rtl/requant_pack_pkg.sv
// Shared constants and round/shift/saturate helpers for the requant_pack datapath.
// Optional saturation counter is enabled with the REQUANT_SAT_CNT_EN macro.
package requant_pack_pkg;

  localparam int LANES = 7;
  localparam int IW    = 32;
  localparam int OW    = 8;
  localparam int SW    = 16;
  localparam int SHW   = 5;
  localparam int PACK  = 4;
  localparam int PW    = IW + SW + 1;
  localparam int RW    = PW + 1;
  localparam int SLOTW = LANES * OW;
  localparam int WORDW = PACK * SLOTW;
  localparam int IDXW  = $clog2(PACK);

  localparam logic signed [OW-1:0] QMIN = -8'sd128;
  localparam logic signed [OW-1:0] QMAX = 8'sd127;

  // One guard bit above the product keeps the rounding add from overflowing.
  function automatic logic signed [RW-1:0] rnd_shift(input logic signed [PW-1:0] prod,
                                                     input logic [SHW-1:0] sh);
    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] half;
    logic [RW-1:0]        one;
    ext  = {prod[PW-1], prod};
    one  = RW'(1);
    half = (one << sh) >> 1;
    return (ext + half) >>> sh;
  endfunction

  function automatic logic clamped(input logic signed [RW-1:0] r);
    return (r > RW'(QMAX)) || (r < RW'(QMIN));
  endfunction

  function automatic logic [OW-1:0] sat8(input logic signed [RW-1:0] r);
    if (r > RW'(QMAX))      return QMAX;
    else if (r < RW'(QMIN)) return QMIN;
    else                    return r[OW-1:0];
  endfunction

  function automatic logic [OW-1:0] round_sat(input logic signed [PW-1:0] prod,
                                              input logic [SHW-1:0] sh);
    return sat8(rnd_shift(prod, sh));
  endfunction

endpackage

// File: rtl/requant_pack_lane.sv
// One requant lane: S1 registers din*scale, S2 registers the rounded, shifted, saturated int8.
// With REQUANT_SAT_CNT_EN a combinational clamp flag for the S2 input is exported.
module requant_pack_lane
  import requant_pack_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s1_en_i,
  input  logic           s2_en_i,
  input  logic [IW-1:0]  din_i,
  input  logic [SW-1:0]  scale_i,
  input  logic [SHW-1:0] shift_i,
`ifdef REQUANT_SAT_CNT_EN
  output logic           sat_o,
`endif
  output logic [OW-1:0]  q_o
);

  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [RW-1:0] r;
  logic [OW-1:0]        q_q, q_d;

  assign prod_d = $signed(din_i) * $signed({1'b0, scale_i});
  assign r      = rnd_shift(prod_q, shift_i);
  assign q_d    = sat8(r);
  assign q_o    = q_q;

`ifdef REQUANT_SAT_CNT_EN
  assign sat_o = clamped(r);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      q_q    <= '0;
    end else begin
      if (s1_en_i) prod_q <= prod_d;
      if (s2_en_i) q_q    <= q_d;
    end
  end

endmodule

// File: rtl/requant_pack.sv
// Requantize 7 int32 lanes to int8 and pack 4 beats per 224-bit output word.
// Define REQUANT_SAT_CNT_EN to add the sat_clr_i / sat_cnt_o clamp counter.
module requant_pack
  import requant_pack_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SW-1:0]         scale_i,
  input  logic [SHW-1:0]        shift_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_last_i,
  input  logic [LANES*IW-1:0]   din_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic [PACK-1:0]       out_mask_o,
  output logic [WORDW-1:0]      dout_o,
`ifdef REQUANT_SAT_CNT_EN
  input  logic                  sat_clr_i,
  output logic [31:0]           sat_cnt_o,
`endif
  output logic                  idle_o
);

  logic             stall, accept, s2_en, pack_en, complete;
  logic             s1_valid_q, s1_last_q, s2_valid_q, s2_last_q;
  logic [IDXW-1:0]  idx_q;
  logic [PACK-1:0]  mask_q, wr_mask;
  logic [WORDW-1:0] buf_q, wr_buf;
  logic [SLOTW-1:0] lane_word;
  logic             out_valid_q, out_last_q;
  logic [PACK-1:0]  out_mask_q;
  logic [WORDW-1:0] dout_q;

  assign stall      = out_valid_q && !out_ready_i;
  assign in_ready_o = !stall;
  assign accept     = in_valid_i && !stall;
  assign s2_en      = s1_valid_q && !stall;
  assign pack_en    = s2_valid_q && !stall;
  assign complete   = pack_en && ((idx_q == IDXW'(PACK - 1)) || s2_last_q);

`ifdef REQUANT_SAT_CNT_EN
  logic [LANES-1:0] sat_vec;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    requant_pack_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .s1_en_i (accept),
      .s2_en_i (s2_en),
      .din_i   (din_i[g*IW +: IW]),
      .scale_i (scale_i),
      .shift_i (shift_i),
`ifdef REQUANT_SAT_CNT_EN
      .sat_o   (sat_vec[g]),
`endif
      .q_o     (lane_word[g*OW +: OW])
    );
  end

  always_comb begin
    wr_buf = buf_q;
    wr_buf[int'(idx_q)*SLOTW +: SLOTW] = lane_word;
    wr_mask = mask_q | (PACK'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      idx_q       <= '0;
      mask_q      <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_mask_q  <= '0;
      dout_q      <= '0;
    end else begin
      if (!stall) begin
        s1_valid_q <= accept;
        s1_last_q  <= in_last_i;
        s2_valid_q <= s1_valid_q;
        s2_last_q  <= s1_last_q;
      end
      // The buffer is cleared on every completion, so unfilled slots read back as zero.
      if (complete) begin
        idx_q       <= '0;
        mask_q      <= '0;
        buf_q       <= '0;
        dout_q      <= wr_buf;
        out_mask_q  <= wr_mask;
        out_last_q  <= s2_last_q;
        out_valid_q <= 1'b1;
      end else begin
        if (pack_en) begin
          idx_q  <= idx_q + IDXW'(1);
          mask_q <= wr_mask;
          buf_q  <= wr_buf;
        end
        if (out_ready_i) out_valid_q <= 1'b0;
      end
    end
  end

`ifdef REQUANT_SAT_CNT_EN
  logic [31:0] sat_cnt_q;
  logic [3:0]  nsat;
  logic [32:0] sat_sum;

  always_comb begin
    nsat = '0;
    for (int i = 0; i < LANES; i++) nsat = nsat + 4'(sat_vec[i]);
    sat_sum = {1'b0, sat_cnt_q} + 33'(nsat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sat_cnt_q <= '0;
    else if (sat_clr_i) sat_cnt_q <= '0;
    else if (s2_en)     sat_cnt_q <= sat_sum[32] ? '1 : sat_sum[31:0];
  end

  assign sat_cnt_o = sat_cnt_q;
`endif

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_mask_o  = out_mask_q;
  assign dout_o      = dout_q;
  assign idle_o      = !s1_valid_q && !s2_valid_q && (mask_q == '0) && !out_valid_q;

endmodule

// File: tb/tb_requant_pack.sv
// Self-checking bench for requant_pack: scoreboard of expected packed words plus scenario tasks.
module tb_requant_pack;
  import requant_pack_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [SW-1:0]       scale_i;
  logic [SHW-1:0]      shift_i;
  logic                in_valid_i, in_ready_o, in_last_i;
  logic [LANES*IW-1:0] din_i;
  logic                out_valid_o, out_ready_i, out_last_o;
  logic [PACK-1:0]     out_mask_o;
  logic [WORDW-1:0]    dout_o;
  logic                idle_o;
`ifdef REQUANT_SAT_CNT_EN
  logic                sat_clr_i;
  logic [31:0]         sat_cnt_o;
`endif

  always #5 clk = ~clk;

  requant_pack dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scale_i     (scale_i),
    .shift_i     (shift_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_last_i   (in_last_i),
    .din_i       (din_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_last_o  (out_last_o),
    .out_mask_o  (out_mask_o),
    .dout_o      (dout_o),
`ifdef REQUANT_SAT_CNT_EN
    .sat_clr_i   (sat_clr_i),
    .sat_cnt_o   (sat_cnt_o),
`endif
    .idle_o      (idle_o)
  );

  typedef struct {
    logic [WORDW-1:0] d;
    logic [PACK-1:0]  m;
    logic             l;
  } word_t;

  word_t            sb[$];
  logic [WORDW-1:0] acc_d;
  logic [PACK-1:0]  acc_m;
  int               acc_idx;
  int               total = 0;
  int               bad   = 0;

  function automatic logic [7:0] ref_q(input longint x, input longint sc, input int sh);
    longint p, r;
    p = x * sc;
    if (sh == 0) r = p;
    else r = (p + (longint'(1) << (sh - 1))) >>> sh;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  function automatic logic [LANES*IW-1:0] all_lanes(input int v);
    logic [LANES*IW-1:0] d;
    for (int i = 0; i < LANES; i++) d[i*IW +: IW] = IW'(v);
    return d;
  endfunction

  // Monitor: a word transfers on the next rising edge when valid && ready at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got mask=%b last=%b dout=%h, expected no word", out_mask_o, out_last_o, dout_o);
      end else begin
        word_t w;
        w = sb.pop_front();
        if (dout_o !== w.d || out_mask_o !== w.m || out_last_o !== w.l) begin
          bad++;
          $display("FAIL sb_word: got mask=%b last=%b dout=%h, expected mask=%b last=%b dout=%h",
                   out_mask_o, out_last_o, dout_o, w.m, w.l, w.d);
        end
      end
    end
  end

  task automatic model_clear();
    acc_d = '0; acc_m = '0; acc_idx = 0;
    sb.delete();
  endtask

  task automatic send_beat(input logic [LANES*IW-1:0] d, input logic last);
    bit done;
    for (int i = 0; i < LANES; i++)
      acc_d[acc_idx*SLOTW + i*OW +: OW] = ref_q(longint'($signed(d[i*IW +: IW])), longint'(scale_i), int'(shift_i));
    acc_m[acc_idx] = 1'b1;
    if (acc_idx == PACK - 1 || last) begin
      sb.push_back('{d: acc_d, m: acc_m, l: last});
      acc_d = '0; acc_m = '0; acc_idx = 0;
    end else acc_idx++;
    in_valid_i = 1'b1; din_i = d; in_last_i = last;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      done = in_ready_o;
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0; in_last_i = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end
  endtask

  task automatic wait_valid(input string nm);
    bit ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (out_valid_o) ok = 1;
      else begin @(posedge clk); #1; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s_valid_timeout: out_valid=0, expected 1", nm); end
  endtask

  task automatic wait_drain(input string nm);
    bit ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && idle_o) ok = 1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d idle=%b, expected 0 and 1", nm, sb.size(), idle_o);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #7;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs(input string nm);
    total++;
    if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || out_mask_o !== '0 || dout_o !== '0 ||
        idle_o !== 1'b1 || in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s: got valid=%b last=%b mask=%b dout_nz=%b idle=%b in_ready=%b, expected 0 0 0000 0 1 1",
               nm, out_valid_o, out_last_o, out_mask_o, |dout_o, idle_o, in_ready_o);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_outs("reset_state");
  endtask

  task automatic test_basic();
    int vals[4] = '{5, -3, 127, 0};
    scale_i = 16'd1; shift_i = 5'd0; out_ready_i = 1'b1;
    for (int b = 0; b < 4; b++) send_beat(all_lanes(vals[b]), 1'b0);
    total++;
    if (out_valid_o !== 1'b0) begin bad++; $display("FAIL lat_e0: out_valid=%b, expected 0", out_valid_o); end
    @(posedge clk); #1;
    total++;
    if (out_valid_o !== 1'b0) begin bad++; $display("FAIL lat_e1: out_valid=%b, expected 0", out_valid_o); end
    @(posedge clk); #1;
    total++;
    if (out_valid_o !== 1'b1) begin bad++; $display("FAIL lat_e2: out_valid=%b, expected 1", out_valid_o); end
    total++;
    if (out_mask_o !== 4'b1111 || out_last_o !== 1'b0 || dout_o[7:0] !== 8'h05 ||
        dout_o[SLOTW +: 8] !== 8'hFD || dout_o[2*SLOTW + 6*OW +: 8] !== 8'h7F || dout_o[3*SLOTW +: SLOTW] !== '0) begin
      bad++;
      $display("FAIL basic_word: got mask=%b last=%b dout=%h, expected mask=1111 last=0 bytes 05/fd/7f/00",
               out_mask_o, out_last_o, dout_o);
    end
    wait_drain("basic");
  endtask

  task automatic test_round();
    logic [LANES*IW-1:0] d;
    int v[LANES] = '{5, 6, -6, 1000, -1000, 2, -1};
    scale_i = 16'd3; shift_i = 5'd2;
    for (int i = 0; i < LANES; i++) d[i*IW +: IW] = IW'(v[i]);
    send_beat(d, 1'b1);
    wait_valid("round");
    total++;
    if (dout_o[0 +: 8] !== 8'd4 || dout_o[8 +: 8] !== 8'd5 || dout_o[16 +: 8] !== 8'hFC ||
        dout_o[24 +: 8] !== 8'h7F || dout_o[32 +: 8] !== 8'h80 || out_mask_o !== 4'b0001) begin
      bad++;
      $display("FAIL round_bytes: got %h mask=%b, expected 80 7f fc 05 04 (msb first) mask=0001",
               dout_o[39:0], out_mask_o);
    end
    wait_drain("round");
  endtask

  task automatic test_partial();
    scale_i = 16'd1; shift_i = 5'd0;
    send_beat(all_lanes(11), 1'b0);
    send_beat(all_lanes(-22), 1'b1);
    wait_valid("partial");
    total++;
    if (out_mask_o !== 4'b0011 || out_last_o !== 1'b1 || dout_o[2*SLOTW +: 2*SLOTW] !== '0) begin
      bad++;
      $display("FAIL partial_word: got mask=%b last=%b upper_nz=%b, expected 0011 1 0",
               out_mask_o, out_last_o, |dout_o[2*SLOTW +: 2*SLOTW]);
    end
    for (int b = 0; b < 4; b++) send_beat(all_lanes(b * 7 - 9), b == 3);
    wait_drain("partial");
  endtask

  task automatic test_stall();
    scale_i = 16'd2; shift_i = 5'd1; out_ready_i = 1'b0;
    fork
      for (int b = 0; b < 8; b++) send_beat(all_lanes($urandom_range(0, 300) - 150), 1'b0);
      begin
        logic [WORDW-1:0] cap_d;
        logic [PACK-1:0]  cap_m;
        logic             cap_l;
        wait_valid("stall");
        cap_d = dout_o; cap_m = out_mask_o; cap_l = out_last_o;
        for (int c = 0; c < 5; c++) begin
          @(posedge clk); #1;
          total++;
          if (in_ready_o !== 1'b0 || dout_o !== cap_d || out_mask_o !== cap_m || out_last_o !== cap_l) begin
            bad++;
            $display("FAIL stall_hold: got in_ready=%b held=%b, expected in_ready=0 held=1",
                     in_ready_o, (dout_o === cap_d && out_mask_o === cap_m && out_last_o === cap_l));
          end
        end
        out_ready_i = 1'b1;
      end
    join
    wait_drain("stall");
  endtask

  task automatic test_reset_mid();
    scale_i = 16'd1; shift_i = 5'd0; out_ready_i = 1'b0;
    for (int b = 0; b < 6; b++) send_beat(all_lanes(b + 1), 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("reset_mid_stalled");
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready_i = 1'b1;
    for (int b = 0; b < 3; b++) send_beat(all_lanes(40 + b), 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("reset_mid_3beats");
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int b = 0; b < 4; b++) send_beat(all_lanes(-60 + b), 1'b0);
    wait_valid("after_reset");
    total++;
    if (out_mask_o !== 4'b1111 || dout_o[7:0] !== 8'hC4) begin
      bad++;
      $display("FAIL after_reset_word: got mask=%b byte0=%h, expected 1111 c4", out_mask_o, dout_o[7:0]);
    end
    wait_drain("after_reset");
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b1;
    for (int round = 0; round < 3; round++) begin
      logic [LANES*IW-1:0] d;
      scale_i = SW'($urandom_range(1, 65535));
      shift_i = SHW'($urandom_range(0, 31));
      fork
        for (int b = 0; b < 12; b++) begin
          for (int i = 0; i < LANES; i++) d[i*IW +: IW] = IW'($urandom);
          send_beat(d, ($urandom_range(0, 5) == 0));
        end
        for (int c = 0; c < 40; c++) begin
          @(posedge clk); #1;
          out_ready_i = (round == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
      join
      out_ready_i = 1'b1;
      if (acc_idx != 0) send_beat(all_lanes(1), 1'b1);
      wait_drain("b2b");
    end
  endtask

`ifdef REQUANT_SAT_CNT_EN
  task automatic test_sat_cnt();
    scale_i = 16'd1; shift_i = 5'd0; out_ready_i = 1'b1;
    sat_clr_i = 1'b1;
    @(posedge clk); #1 sat_clr_i = 1'b0;
    total++;
    if (sat_cnt_o !== 32'd0) begin bad++; $display("FAIL sat_clr0: got %0d, expected 0", sat_cnt_o); end
    send_beat(all_lanes(1 << 20), 1'b1);
    wait_drain("sat");
    total++;
    if (sat_cnt_o !== 32'd7) begin bad++; $display("FAIL sat_cnt7: got %0d, expected 7", sat_cnt_o); end
    sat_clr_i = 1'b1;
    send_beat(all_lanes(-(1 << 20)), 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    sat_clr_i = 1'b0;
    total++;
    if (sat_cnt_o !== 32'd0) begin bad++; $display("FAIL sat_clr_prio: got %0d, expected 0", sat_cnt_o); end
    wait_drain("sat2");
  endtask
`endif

  initial begin
    rst_n = 1'b0; scale_i = '0; shift_i = '0; in_valid_i = 1'b0; in_last_i = 1'b0;
    din_i = '0; out_ready_i = 1'b1;
`ifdef REQUANT_SAT_CNT_EN
    sat_clr_i = 1'b0;
`endif
    model_clear();
    test_reset();
    test_basic();
    test_round();
    test_partial();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef REQUANT_SAT_CNT_EN
    test_sat_cnt();
`endif
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
